// File: rtl/kgp_mem_pkg.sv
// Shared types and defaults for the KGP-RISC memory-stage store buffer.
package kgp_mem_pkg;
  localparam int AW_DEF       = 10;
  localparam int SB_DEPTH_DEF = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [31:0]       data;
  } sb_entry_t;

  typedef enum logic {SB_RUN = 1'b0, SB_FENCE = 1'b1} sb_state_e;
endpackage

// File: rtl/sb_match.sv
// Address compare across all buffer entries with youngest-first priority select.
module sb_match
  import kgp_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = AW_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0]              addr_i,
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [PW-1:0]              tail_i,
  input  logic [DEPTH-1:0][AW-1:0]   ent_addr_i,
  input  logic [DEPTH-1:0][31:0]     ent_data_i,
  output logic                       hit_o,
  output logic [PW-1:0]              idx_o,
  output logic [31:0]                data_o
);
  logic [DEPTH-1:0] match;
  logic [PW-1:0]    cand;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g] = valid_i[g] && (ent_addr_i[g] == addr_i);
  end

  // Walk oldest to youngest (tail-DEPTH .. tail-1) so the youngest match is the last to win.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      cand = tail_i - PW'(k + 1);
      if (match[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
    data_o = ent_data_i[idx_o];
  end
endmodule

// File: rtl/store_buffer.sv
// In-order store buffer with load forwarding and fence drain for the MEM stage.
// Optional in-place store coalescing is enabled by defining STBUF_COALESCE_EN.
module store_buffer
  import kgp_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = AW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_we,
  input  logic          mem_re,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  input  logic          fence,
  output logic          mem_stall,
  output logic          dm_write,
  output logic          dm_read,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_din,
  input  logic [31:0]   dm_dout,
  output logic [CW-1:0] sb_count
);
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][31:0]   data_q;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  sb_state_e                state_q, state_d;

  logic [DEPTH-1:0] valid;
  logic             hit;
  logic [PW-1:0]    hit_idx;
  logic [31:0]      fwd_data;
  logic             full, empty, fence_hold;
  logic             port_req, load_act, store_act, drain, coal, enq;

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    assign valid[g] = {1'b0, PW'(PW'(g) - head_q)} < count_q;
  end

  sb_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .addr_i     (mem_addr[AW-1:0]),
    .valid_i    (valid),
    .tail_i     (tail_q),
    .ent_addr_i (addr_q),
    .ent_data_i (data_q),
    .hit_o      (hit),
    .idx_o      (hit_idx),
    .data_o     (fwd_data)
  );

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A load request reserves the port even when a simultaneous store wins,
  // so stores issued under back-to-back loads accumulate in the buffer.
  assign port_req  = ~reset & ~fence_hold & mem_re;
  assign load_act  = port_req & ~mem_we;
  assign store_act = ~reset & ~fence_hold & mem_we;
  assign drain     = ~reset & ~empty & ~port_req;

`ifdef STBUF_COALESCE_EN
  // Merging into the head as it drains would lose the new data; enqueue instead.
  assign coal = store_act & hit & ~(drain & (hit_idx == head_q));
`else
  assign coal = 1'b0;
`endif
  assign enq = store_act & ~coal & ~full;

  assign head_d  = head_q + PW'(drain);
  assign tail_d  = tail_q + PW'(enq);
  assign count_d = count_q + CW'(enq) - CW'(drain);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= SB_RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:   if (fence && !empty && count_d != '0) state_d = SB_FENCE;
      SB_FENCE: if (count_d == '0) state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fence_hold = ~reset & ((state_q == SB_FENCE) | (fence & ~empty));
    mem_stall  = fence_hold | (store_act & ~coal & full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= mem_addr[AW-1:0];
      data_q[tail_q] <= mem_wdata;
    end
    if (coal) data_q[hit_idx] <= mem_wdata;
  end

  assign dm_write  = drain;
  assign dm_read   = load_act;
  assign dm_din    = drain ? data_q[head_q] : 32'd0;
  assign dm_addr   = load_act ? mem_addr :
                     drain    ? {{(32-AW){1'b0}}, addr_q[head_q]} : 32'd0;
  assign mem_rdata = load_act ? (hit ? fwd_data : dm_dout) : 32'd0;
  assign sb_count  = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed scenarios.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, mem_we, mem_re, fence;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dm_addr, dm_din, dm_dout;
  logic        mem_stall, dm_write, dm_read;
  logic [2:0]  sb_count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fence(fence), .mem_stall(mem_stall), .dm_write(dm_write), .dm_read(dm_read),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout), .sb_count(sb_count)
  );

  // Data memory: unwritten words read back a recognisable pattern.
  logic [31:0] dmem [1024];
  bit          dval [1024];
  always @(posedge clk) begin
    if (dm_write) begin
      dmem[dm_addr[9:0]] <= dm_din;
      dval[dm_addr[9:0]] <= 1'b1;
    end
  end
  assign dm_dout = dval[dm_addr[9:0]] ? dmem[dm_addr[9:0]] : (32'hD000_0000 | {22'b0, dm_addr[9:0]});

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, memory as an array.
  typedef struct {logic [9:0] a; logic [31:0] d;} ent_t;
  ent_t        q[$];
  logic [31:0] mmem [1024];
  bit          mval [1024];
  bit          fst = 1'b0;

  function automatic logic [31:0] mrd(input logic [9:0] a);
    return mval[a] ? mmem[a] : (32'hD000_0000 | {22'b0, a});
  endfunction

  initial begin : model
    int n, hi;
    bit hold, lreq, ld, st, dr, co, enq, stl, hit;
    logic [9:0]  a;
    logic [31:0] er, ea, ed;
    forever begin
      @(negedge clk);
      n = q.size();
      chk("sb_count", 32'(sb_count), 32'(n));
      if (reset) begin
        chk("rst_dm_write", 32'(dm_write), 0);
        chk("rst_dm_read", 32'(dm_read), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_rdata", mem_rdata, 0);
        q.delete();
        fst = 1'b0;
      end else begin
        a    = mem_addr[9:0];
        hold = fst || (fence && n > 0);
        lreq = mem_re && !hold;
        ld   = lreq && !mem_we;
        st   = mem_we && !hold;
        dr   = (n > 0) && !lreq;
        hit  = 1'b0;
        hi   = 0;
        for (int i = 0; i < n; i++) if (q[i].a == a) begin hit = 1'b1; hi = i; end
        co = 1'b0;
`ifdef STBUF_COALESCE_EN
        co = st && hit && !(dr && hi == 0);
`endif
        enq = st && !co && (n < DEPTH);
        stl = hold || (st && !co && n == DEPTH);
        er  = ld ? (hit ? q[hi].d : mrd(a)) : 32'd0;
        ea  = ld ? mem_addr : (dr ? {22'b0, q[0].a} : 32'd0);
        ed  = dr ? q[0].d : 32'd0;
        chk("mem_stall", 32'(mem_stall), 32'(stl));
        chk("dm_write", 32'(dm_write), 32'(dr));
        chk("dm_read", 32'(dm_read), 32'(ld));
        chk("mem_rdata", mem_rdata, er);
        chk("dm_din", dm_din, ed);
        if (ld || dr) chk("dm_addr", dm_addr, ea);
        if (co) q[hi].d = mem_wdata;
        if (dr) begin
          mmem[q[0].a] = q[0].d;
          mval[q[0].a] = 1'b1;
          void'(q.pop_front());
        end
        if (enq) q.push_back('{a, mem_wdata});
        fst = fst ? (q.size() != 0) : (fence && n > 0 && q.size() > 0);
      end
    end
  end

  // Drive one cycle; returns at the following negedge with that cycle's outputs settled.
  task automatic cyc(input bit r, we, re, f, input logic [31:0] a, d);
    @(posedge clk);
    #1;
    reset = r; mem_we = we; mem_re = re; fence = f; mem_addr = a; mem_wdata = d;
    @(negedge clk);
    #1;
  endtask

  initial begin : stim
    int k;
    reset = 1'b1; mem_we = 1'b0; mem_re = 1'b0; fence = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_count", 32'(sb_count), 0);

    // Basic drain
    cyc(0, 1, 1, 0, 5, 32'h11);
    cyc(0, 1, 1, 0, 6, 32'h22);
    chk("drain_cnt1", 32'(sb_count), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_cnt2", 32'(sb_count), 2);
    chk("drain_w1", 32'(dm_write), 1);
    chk("drain_a1", dm_addr, 5);
    chk("drain_d1", dm_din, 32'h11);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_cnt3", 32'(sb_count), 1);
    chk("drain_a2", dm_addr, 6);
    chk("drain_d2", dm_din, 32'h22);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_cnt4", 32'(sb_count), 0);
    chk("drain_idle", 32'(dm_write), 0);

    // Forwarding
    cyc(0, 1, 1, 0, 7, 32'hAA);
    cyc(0, 0, 1, 0, 7, 0);
    chk("fwd_hit", mem_rdata, 32'hAA);
    chk("fwd_no_write", 32'(dm_write), 0);
    cyc(0, 0, 1, 0, 8, 0);
    chk("fwd_miss", mem_rdata, 32'hD000_0008);
    cyc(0, 0, 0, 0, 0, 0);

    // Youngest duplicate wins
    cyc(0, 1, 1, 0, 3, 1);
    cyc(0, 1, 1, 0, 3, 2);
    cyc(0, 0, 1, 0, 3, 0);
    chk("youngest_fwd", mem_rdata, 2);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("youngest_mem", dmem[3], 2);

    // Full stall: fill under loads, retry the 5th store once the port is free
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 32'h40 + i, 32'h100 + i);
    cyc(0, 1, 1, 0, 32'h44, 32'h104);
    chk("full_stall", 32'(mem_stall), 1);
    k = 0;
    while (mem_stall && k < 20) begin
      k++;
      cyc(0, 1, 0, 0, 32'h44, 32'h104);
    end
    chk("full_retry_done", 32'(mem_stall), 0);
    repeat (6) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) chk("full_mem", dmem[32'h40 + i], 32'h100 + i);

    // Fence with three buffered stores
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 32'h50 + i, 32'h150 + i);
    cyc(0, 0, 0, 1, 0, 0);
    k = 0;
    while (mem_stall && k < 10) begin
      k++;
      cyc(0, 0, 0, 1, 0, 0);
    end
    chk("fence_stall_cycles", 32'(k), 3);
    chk("fence_empty", 32'(sb_count), 0);
    cyc(0, 0, 1, 0, 32'h50, 0);
    chk("fence_run_load", mem_rdata, 32'h150);
    chk("fence_run_nostall", 32'(mem_stall), 0);

    // Reset while draining
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 32'h60 + i, 32'h160 + i);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_mid_nowrite", 32'(dm_write), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_mid_count", 32'(sb_count), 0);
    chk("rst_mid_write", 32'(dm_write), 0);
    cyc(0, 0, 1, 0, 32'h60, 0);
    chk("rst_mid_nofwd", mem_rdata, 32'hD000_0060);
    cyc(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1024; i++)
      if (dval[i] || mval[i]) chk("mem_final", dval[i] ? dmem[i] : 32'hD000_0000 | i, mrd(10'(i)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
